vga_text_renderer: RTL
======================

VGA_TEXT_RENDERER -- requirements
Module: vga_text_renderer

Interface
REQ-001 Parameter CLEAR_CHAR, default 8'h20: code written to every cell by a clear sweep.
REQ-002 Parameter BLINK_BIT, default 4: frame-counter bit that drives cursor blink phase (32-frame period).
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 clk  in  1  pixel clock, shared with the sync generator.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 counter_x  in  10  horizontal pixel counter from the sync generator.
REQ-007 counter_y  in  10  vertical line counter from the sync generator.
REQ-008 in_display_select  in  1  high inside the 640x480 visible area.
REQ-009 h_sync_in / v_sync_in  in  1 each  active-low syncs from the sync generator.
REQ-010 wr_en  in  1  write request for one character cell.
REQ-011 wr_col  in  7  target column, 0..79.
REQ-012 wr_row  in  5  target row, 0..29.
REQ-013 wr_char  in  8  character code to store.
REQ-014 wr_ready  out  1  high when writes are accepted.
REQ-015 clear_req  in  1  single-cycle pulse that starts a full-buffer clear.
REQ-016 cursor_col / cursor_row  in  7 / 5  cursor cell position.
REQ-017 font_addr  out  12  registered font ROM address {char[7:0], line_in_cell[3:0]}.
REQ-018 font_data  in  8  glyph row from the external font ROM; valid exactly one clock after font_addr; bit 7 is the leftmost pixel.
REQ-019 pixel_on  out  1  foreground pixel.
REQ-020 h_sync_out / v_sync_out  out  1 each  syncs delayed to align with pixel_on.

Function
REQ-021 The screen SHALL be 80x30 cells of 8x16 pixels: col = counter_x[9:3], line = counter_y[3:0], row = counter_y[8:4].
REQ-022 The character buffer SHALL be 2400x8, addressed row*80+col (12-bit), with a synchronous read and a read-first policy on same-address read/write.
REQ-023 The render pipeline SHALL be 4 stages; inputs sampled at edge N produce pixel_on, h_sync_out and v_sync_out at edge N+4, with no bubbles.
REQ-024 Pipeline stages: S1 buffer read plus register col, row, line, counter_x[2:0], display and syncs; S2 font_addr <= {char, line}; S3 font_data returned; S4 pixel select.
REQ-025 pixel_on SHALL equal font_data[7 - x_bit] XOR cursor_hit, forced to 0 when the delayed in_display_select is 0.
REQ-026 cursor_hit SHALL be 1 only when cell == (cursor_col, cursor_row), line is 14 or 15, and blink_phase is 1.
REQ-027 A 5-bit frame counter SHALL increment on each falling edge of v_sync_in, detected against a registered copy, and wrap 31->0; blink_phase = frame_cnt[BLINK_BIT].
REQ-028 A write SHALL be accepted when wr_en & wr_ready; the cell is updated on that edge.
REQ-029 A write with wr_col >= 80 or wr_row >= 30 SHALL be dropped, with no wrap and no other cell altered.
REQ-030 Clear FSM states:
- IDLE -> CLEAR on clear_req while wr_ready = 1.
- CLEAR writes CLEAR_CHAR to address 0..2399, one address per clock.
- CLEAR -> IDLE after address 2399; the sweep takes 2400 cycles.
REQ-031 wr_ready SHALL be 0 throughout CLEAR and 1 in IDLE.
REQ-032 wr_en and clear_req SHALL be ignored during CLEAR.
REQ-033 If clear_req and wr_en are both high in IDLE, the write SHALL be accepted first and CLEAR SHALL start on the same edge.
REQ-034 Rendering SHALL continue during CLEAR, showing the partially cleared buffer.
REQ-035 Counters beyond 639/479 SHALL NOT generate out-of-range buffer addresses; the address is clamped to 0 while the display flag is 0.

Reset
REQ-036 On reset assertion, outputs SHALL immediately go to: pixel_on=0, h_sync_out=1, v_sync_out=1, font_addr=0, wr_ready=1.
REQ-037 On reset assertion, frame_cnt, clear address and all pipeline registers SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-038 Reset during CLEAR SHALL abort the sweep; buffer contents are not reset and remain as partially written.
REQ-039 Outputs SHALL be valid from the 4th clock after reset deassertion.

Verification
REQ-040 Write 'A' (8'h41) at (0,0); scan line 0 with a font model -> font_addr = 12'h410 at the edge 2 clocks after counter (0,0); pixel_on follows glyph bits at edge +4.
REQ-041 Write at (80,5) and at (3,30) -> wr_ready stays 1; a full-frame readback shows no cell changed.
REQ-042 Pulse clear_req -> wr_ready=0 for exactly 2400 cycles; all cells read 8'h20; a wr_en issued mid-sweep is lost.
REQ-043 Cursor at (10,2), glyph all zeros -> pixel_on=1 only on x 80..87, y 46..47, and only in frames where frame_cnt[4]=1 (frames 16..31 of each 32).
REQ-044 Assert reset mid-clear at address 1000 -> wr_ready=1 immediately; cells 0..999 read 8'h20 and cells 1000..2399 hold their prior data.
REQ-045 Same-cycle write and render read of the same cell -> the old character is displayed that frame and the new character the next frame; sync outputs lag inputs by exactly 4 clocks.

Source files
------------

// File: rtl/vga_text_renderer.sv
// 80x30 character-cell text renderer: 2400x8 char buffer, clear sweep FSM, cursor blink.
// Latency: inputs sampled at edge N appear on pixel_on / h_sync_out / v_sync_out at edge N+4.
// Backpressure: wr_ready drops for the 2400-cycle clear sweep; writes and clears are ignored then.
module vga_text_renderer #(
   parameter logic [7:0] CLEAR_CHAR = 8'h20,
   parameter int         BLINK_BIT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  counter_x,
   input  logic [9:0]  counter_y,
   input  logic        in_display_select,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   input  logic        wr_en,
   input  logic [6:0]  wr_col,
   input  logic [4:0]  wr_row,
   input  logic [7:0]  wr_char,
   output logic        wr_ready,
   input  logic        clear_req,
   input  logic [6:0]  cursor_col,
   input  logic [4:0]  cursor_row,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        pixel_on,
   output logic        h_sync_out,
   output logic        v_sync_out
);

   localparam logic [6:0]  NUM_COLS  = 7'd80;
   localparam logic [4:0]  NUM_ROWS  = 5'd30;
   localparam logic [11:0] LAST_CELL = 12'd2399;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   // clear sweep state
   state_t      r_state;
   logic [11:0] r_clr_addr;
   logic        r_wr_ready;

   // frame counter for cursor blink
   logic        r_vs_prev;
   logic [4:0]  r_frame_cnt;

   // character buffer
   logic [7:0]  r_mem [0:2399];

   // S1: buffer read result plus sidebands
   logic [7:0]  r_s1_char;
   logic [6:0]  r_s1_col;
   logic [4:0]  r_s1_row;
   logic [3:0]  r_s1_line;
   logic [2:0]  r_s1_xbit;
   logic        r_s1_disp;
   logic        r_s1_hs;
   logic        r_s1_vs;

   // S2: font address issued, cursor decision made
   logic [11:0] r_font_addr;
   logic [2:0]  r_s2_xbit;
   logic        r_s2_disp;
   logic        r_s2_cur;
   logic        r_s2_hs;
   logic        r_s2_vs;

   // S3: font ROM access in flight
   logic [2:0]  r_s3_xbit;
   logic        r_s3_disp;
   logic        r_s3_cur;
   logic        r_s3_hs;
   logic        r_s3_vs;

   // S4: glyph row captured, final pixel select feeds the output registers
   logic [7:0]  r_s4_font;
   logic [2:0]  r_s4_xbit;
   logic        r_s4_disp;
   logic        r_s4_cur;
   logic        r_s4_hs;
   logic        r_s4_vs;

   logic        r_pixel_on;
   logic        r_hs_out;
   logic        r_vs_out;

   // render-side address decode
   logic [6:0]  w_col;
   logic [4:0]  w_row;
   logic [3:0]  w_line;
   logic        w_cell_ok;
   logic [11:0] w_rd_addr;

   // write-side address decode and buffer write port mux
   logic        w_wr_in_range;
   logic [11:0] w_wr_addr;
   logic        w_wr_accept;
   logic        w_clearing;
   logic        w_mem_we;
   logic [11:0] w_mem_waddr;
   logic [7:0]  w_mem_wdat;
   logic        w_blink;
   logic        w_cursor_hit;

   assign w_col     = counter_x[9:3];
   assign w_row     = counter_y[8:4];
   assign w_line    = counter_y[3:0];
   // Blanking counters never reach the buffer: the address parks at 0 outside the visible grid.
   assign w_cell_ok = in_display_select && !counter_y[9] &&
                      (w_col < NUM_COLS) && (w_row < NUM_ROWS);
   assign w_rd_addr = w_cell_ok ? ({7'd0, w_row} * 12'd80 + {5'd0, w_col}) : 12'd0;

   assign w_wr_in_range = (wr_col < NUM_COLS) && (wr_row < NUM_ROWS);
   assign w_wr_addr     = {7'd0, wr_row} * 12'd80 + {5'd0, wr_col};
   assign w_wr_accept   = wr_en && r_wr_ready && w_wr_in_range;
   assign w_clearing    = (r_state == ST_CLEAR);
   assign w_mem_we      = w_wr_accept || w_clearing;
   assign w_mem_waddr   = w_clearing ? r_clr_addr : w_wr_addr;
   assign w_mem_wdat    = w_clearing ? CLEAR_CHAR : wr_char;

   assign w_blink       = r_frame_cnt[BLINK_BIT];
   // Cursor is an underline on the bottom two scan lines of its cell.
   assign w_cursor_hit  = (r_s1_col == cursor_col) && (r_s1_row == cursor_row) &&
                          (r_s1_line[3:1] == 3'b111) && w_blink;

   // Buffer write port; contents are intentionally left untouched by reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdat;
      end
   end

   // Clear sweep FSM: one cell per clock from 0 to 2399, wr_ready low throughout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_clr_addr <= 12'd0;
         r_wr_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clear_req) begin
                  r_state    <= ST_CLEAR;
                  r_clr_addr <= 12'd0;
                  r_wr_ready <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (r_clr_addr == LAST_CELL) begin
                  r_state    <= ST_IDLE;
                  r_clr_addr <= 12'd0;
                  r_wr_ready <= 1'b1;
               end else begin
                  r_clr_addr <= r_clr_addr + 12'd1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_clr_addr <= 12'd0;
               r_wr_ready <= 1'b1;
            end
         endcase
      end
   end

   // Frame counter advances on each falling edge of v_sync_in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vs_prev   <= 1'b0;
         r_frame_cnt <= 5'd0;
      end else begin
         r_vs_prev <= v_sync_in;
         if (r_vs_prev && !v_sync_in) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
         end
      end
   end

   // S1: synchronous buffer read (old data wins on a same-edge write) and sideband capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_char <= 8'd0;
         r_s1_col  <= 7'd0;
         r_s1_row  <= 5'd0;
         r_s1_line <= 4'd0;
         r_s1_xbit <= 3'd0;
         r_s1_disp <= 1'b0;
         r_s1_hs   <= 1'b1;
         r_s1_vs   <= 1'b1;
      end else begin
         r_s1_char <= r_mem[w_rd_addr];
         r_s1_col  <= w_col;
         r_s1_row  <= w_row;
         r_s1_line <= w_line;
         r_s1_xbit <= counter_x[2:0];
         r_s1_disp <= in_display_select;
         r_s1_hs   <= h_sync_in;
         r_s1_vs   <= v_sync_in;
      end
   end

   // S2: issue the font ROM address and resolve the cursor for this pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_font_addr <= 12'd0;
         r_s2_xbit   <= 3'd0;
         r_s2_disp   <= 1'b0;
         r_s2_cur    <= 1'b0;
         r_s2_hs     <= 1'b1;
         r_s2_vs     <= 1'b1;
      end else begin
         r_font_addr <= {r_s1_char, r_s1_line};
         r_s2_xbit   <= r_s1_xbit;
         r_s2_disp   <= r_s1_disp;
         r_s2_cur    <= w_cursor_hit;
         r_s2_hs     <= r_s1_hs;
         r_s2_vs     <= r_s1_vs;
      end
   end

   // S3: sidebands wait out the one-clock font ROM read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s3_xbit <= 3'd0;
         r_s3_disp <= 1'b0;
         r_s3_cur  <= 1'b0;
         r_s3_hs   <= 1'b1;
         r_s3_vs   <= 1'b1;
      end else begin
         r_s3_xbit <= r_s2_xbit;
         r_s3_disp <= r_s2_disp;
         r_s3_cur  <= r_s2_cur;
         r_s3_hs   <= r_s2_hs;
         r_s3_vs   <= r_s2_vs;
      end
   end

   // S4: capture the returned glyph row alongside its sidebands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s4_font <= 8'd0;
         r_s4_xbit <= 3'd0;
         r_s4_disp <= 1'b0;
         r_s4_cur  <= 1'b0;
         r_s4_hs   <= 1'b1;
         r_s4_vs   <= 1'b1;
      end else begin
         r_s4_font <= font_data;
         r_s4_xbit <= r_s3_xbit;
         r_s4_disp <= r_s3_disp;
         r_s4_cur  <= r_s3_cur;
         r_s4_hs   <= r_s3_hs;
         r_s4_vs   <= r_s3_vs;
      end
   end

   // Output: pick the glyph bit (bit 7 = leftmost), invert under the cursor, blank outside display.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pixel_on <= 1'b0;
         r_hs_out   <= 1'b1;
         r_vs_out   <= 1'b1;
      end else begin
         r_pixel_on <= r_s4_disp & (r_s4_font[~r_s4_xbit] ^ r_s4_cur);
         r_hs_out   <= r_s4_hs;
         r_vs_out   <= r_s4_vs;
      end
   end

   assign wr_ready   = r_wr_ready;
   assign font_addr  = r_font_addr;
   assign pixel_on   = r_pixel_on;
   assign h_sync_out = r_hs_out;
   assign v_sync_out = r_vs_out;

endmodule
